time_set_ctrl: RTL and testbench

//  Consumes the 2-bit press codes from the button state detector and runs an HH:MM time value.
//  In IDLE it advances on an external minute tick. In edit mode the press codes step the hour
//  and minute fields. Outputs are BCD and drive the 7-segment display driver directly.

---
 rtl/time_set_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// HH:MM BCD clock with button-driven edit mode; registered outputs, 1-cycle latency, no backpressure.
// Optional blink strobe for the edited field is built only when TIME_SET_BLINK_EN is defined.
module time_set_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned BLINK_HALF     = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn_state,
  input  logic       tick_min,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [1:0] field_sel,
  output logic       commit,
  output logic       blink
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EDIT_HR  = 2'd1,
    EDIT_MIN = 2'd2
  } state_t;

  localparam logic [1:0]  CODE_STEP = 2'd1;
  localparam logic [1:0]  CODE_NEXT = 2'd2;
  localparam logic [7:0]  HR_MAX    = 8'h23;
  localparam logic [7:0]  MIN_MAX   = 8'h59;
  localparam logic [29:0] TO_LAST   = 30'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  run_hr_q, run_hr_d;
  logic [7:0]  run_min_q, run_min_d;
  logic [7:0]  edit_hr_q, edit_hr_d;
  logic [7:0]  edit_min_q, edit_min_d;
  logic [29:0] to_cnt_q, to_cnt_d;
  logic [7:0]  hr_q, hr_d;
  logic [7:0]  min_q, min_d;
  logic [1:0]  field_q, field_d;
  logic        commit_q, commit_d;

  // BCD increment that wraps to 00 once the value equals lim.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if (v == lim) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      run_hr_q   <= 8'h00;
      run_min_q  <= 8'h00;
      edit_hr_q  <= 8'h00;
      edit_min_q <= 8'h00;
      to_cnt_q   <= 30'd0;
      hr_q       <= 8'h00;
      min_q      <= 8'h00;
      field_q    <= 2'd0;
      commit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_hr_q   <= run_hr_d;
      run_min_q  <= run_min_d;
      edit_hr_q  <= edit_hr_d;
      edit_min_q <= edit_min_d;
      to_cnt_q   <= to_cnt_d;
      hr_q       <= hr_d;
      min_q      <= min_d;
      field_q    <= field_d;
      commit_q   <= commit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_hr_d   = run_hr_q;
    run_min_d  = run_min_q;
    edit_hr_d  = edit_hr_q;
    edit_min_d = edit_min_q;
    to_cnt_d   = to_cnt_q;
    commit_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        to_cnt_d = 30'd0;
        // Entering edit wins over a same-cycle tick, so edit starts from the pre-tick time.
        if (btn_state == CODE_NEXT) begin
          state_d    = EDIT_HR;
          edit_hr_d  = run_hr_q;
          edit_min_d = run_min_q;
        end else if (tick_min) begin
          if (run_min_q == MIN_MAX) begin
            run_min_d = 8'h00;
            run_hr_d  = bcd_inc(run_hr_q, HR_MAX);
          end else begin
            run_min_d = bcd_inc(run_min_q, MIN_MAX);
          end
        end
      end

      EDIT_HR: begin
        if (btn_state == CODE_NEXT) begin
          state_d  = EDIT_MIN;
          to_cnt_d = 30'd0;
        end else if (btn_state == CODE_STEP) begin
          edit_hr_d = bcd_inc(edit_hr_q, HR_MAX);
          to_cnt_d  = 30'd0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d  = IDLE;
          to_cnt_d = 30'd0;
        end else begin
          to_cnt_d = to_cnt_q + 30'd1;
        end
      end

      EDIT_MIN: begin
        if (btn_state == CODE_NEXT) begin
          state_d   = IDLE;
          run_hr_d  = edit_hr_q;
          run_min_d = edit_min_q;
          commit_d  = 1'b1;
          to_cnt_d  = 30'd0;
        end else if (btn_state == CODE_STEP) begin
          edit_min_d = bcd_inc(edit_min_q, MIN_MAX);
          to_cnt_d   = 30'd0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d  = IDLE;
          to_cnt_d = 30'd0;
        end else begin
          to_cnt_d = to_cnt_q + 30'd1;
        end
      end

      default: begin
        state_d  = IDLE;
        to_cnt_d = 30'd0;
      end
    endcase

    if (state_d == IDLE) begin
      hr_d  = run_hr_d;
      min_d = run_min_d;
    end else begin
      hr_d  = edit_hr_d;
      min_d = edit_min_d;
    end
    field_d = state_d;
  end

  assign hr_bcd    = hr_q;
  assign min_bcd   = min_q;
  assign field_sel = field_q;
  assign commit    = commit_q;

`ifdef TIME_SET_BLINK_EN
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] bl_cnt_q, bl_cnt_d;
  logic          blink_q, blink_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bl_cnt_q <= '0;
      blink_q  <= 1'b0;
    end else begin
      bl_cnt_q <= bl_cnt_d;
      blink_q  <= blink_d;
    end
  end

  // Phase restarts visible on a field change or a step so the new digit is shown at once.
  always_comb begin
    bl_cnt_d = bl_cnt_q;
    blink_d  = blink_q;
    if (state_d == IDLE) begin
      bl_cnt_d = '0;
      blink_d  = 1'b0;
    end else if ((state_d != state_q) || (btn_state == CODE_STEP)) begin
      bl_cnt_d = '0;
      blink_d  = 1'b1;
    end else if (bl_cnt_q == BL_LAST) begin
      bl_cnt_d = '0;
      blink_d  = ~blink_q;
    end else begin
      bl_cnt_d = bl_cnt_q + 1'b1;
    end
  end

  assign blink = blink_q;
`else
  if (BLINK_HALF == 0) begin : g_blink_half_unused
  end
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with shortened timeout and blink periods.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn_state = 2'd0;
  logic       tick_min = 1'b0;
  logic [7:0] hr_bcd, min_bcd;
  logic [1:0] field_sel;
  logic       commit, blink;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  time_set_ctrl #(.TIMEOUT_CYCLES(100), .BLINK_HALF(10)) dut (
    .clk(clk), .reset(reset), .btn_state(btn_state), .tick_min(tick_min),
    .hr_bcd(hr_bcd), .min_bcd(min_bcd), .field_sel(field_sel),
    .commit(commit), .blink(blink)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [1:0] code);
    btn_state = code;
    cyc(1);
    btn_state = 2'd0;
  endtask

  task automatic press_n(input logic [1:0] code, input int n);
    repeat (n) press(code);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  // From 00:00: step hours h times and minutes m times, then commit.
  task automatic set_time(input int h, input int m);
    press(2'd2);
    press_n(2'd1, h);
    press(2'd2);
    press_n(2'd1, m);
    press(2'd2);
    cyc(1);
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({hr_bcd, min_bcd, field_sel, commit, blink} !== 20'h0) begin
      bad++;
      $display("FAIL reset_hold: got %h:%h fs=%0d c=%b b=%b want 00:00 0 0 0",
               hr_bcd, min_bcd, field_sel, commit, blink);
    end
    do_reset();
    set_time(7, 45);
    total++;
    if ({hr_bcd, min_bcd} !== 16'h0745) begin
      bad++;
      $display("FAIL preset_0745: got %h:%h want 07:45", hr_bcd, min_bcd);
    end
    press(2'd2);
    press(2'd1);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({hr_bcd, min_bcd, field_sel, commit} !== 19'h0) begin
      bad++;
      $display("FAIL reset_mid_edit: got %h:%h fs=%0d c=%b want 00:00 0 0",
               hr_bcd, min_bcd, field_sel, commit);
    end
    cyc(1);
    reset = 1'b0;
    set_time(3, 0);
    press(2'd2);
    press(2'd2);
    press_n(2'd1, 2);
    btn_state = 2'd2;
    cyc(1);
    btn_state = 2'd0;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({hr_bcd, min_bcd, commit} !== 17'h0) begin
      bad++;
      $display("FAIL reset_on_commit: got %h:%h c=%b want 00:00 0", hr_bcd, min_bcd, commit);
    end
    cyc(1);
    reset = 1'b0;
    cyc(2);
    total++;
    if ({hr_bcd, min_bcd, field_sel, commit} !== 19'h0) begin
      bad++;
      $display("FAIL after_reset: got %h:%h fs=%0d c=%b want 00:00 0 0",
               hr_bcd, min_bcd, field_sel, commit);
    end
  endtask

  task automatic test_tick_wrap();
    do_reset();
    set_time(23, 59);
    total++;
    if ({hr_bcd, min_bcd} !== 16'h2359) begin
      bad++;
      $display("FAIL preset_2359: got %h:%h want 23:59", hr_bcd, min_bcd);
    end
    tick_min = 1'b1;
    cyc(1);
    tick_min = 1'b0;
    total++;
    if ({hr_bcd, min_bcd} !== 16'h0000) begin
      bad++;
      $display("FAIL tick_2359: got %h:%h want 00:00", hr_bcd, min_bcd);
    end
    set_time(9, 59);
    tick_min = 1'b1;
    cyc(1);
    total++;
    if ({hr_bcd, min_bcd} !== 16'h1000) begin
      bad++;
      $display("FAIL tick_0959: got %h:%h want 10:00", hr_bcd, min_bcd);
    end
    cyc(1);
    tick_min = 1'b0;
    total++;
    if ({hr_bcd, min_bcd} !== 16'h1001) begin
      bad++;
      $display("FAIL tick_1000: got %h:%h want 10:01", hr_bcd, min_bcd);
    end
  endtask

  task automatic test_edit_commit();
    do_reset();
    press(2'd2);
    total++;
    if ({field_sel, hr_bcd, min_bcd} !== {2'd1, 16'h0000}) begin
      bad++;
      $display("FAIL enter_edit: got fs=%0d %h:%h want 1 00:00", field_sel, hr_bcd, min_bcd);
    end
    press_n(2'd1, 3);
    press(2'd2);
    total++;
    if ({field_sel, hr_bcd} !== {2'd2, 8'h03}) begin
      bad++;
      $display("FAIL hr_steps: got fs=%0d hr=%h want 2 03", field_sel, hr_bcd);
    end
    press_n(2'd1, 61);
    total++;
    if ({hr_bcd, min_bcd} !== 16'h0301) begin
      bad++;
      $display("FAIL min_wrap_no_carry: got %h:%h want 03:01", hr_bcd, min_bcd);
    end
    press(2'd2);
    total++;
    if ({commit, field_sel, hr_bcd, min_bcd} !== {1'b1, 2'd0, 16'h0301}) begin
      bad++;
      $display("FAIL commit: got c=%b fs=%0d %h:%h want 1 0 03:01",
               commit, field_sel, hr_bcd, min_bcd);
    end
    cyc(1);
    total++;
    if (commit !== 1'b0) begin
      bad++;
      $display("FAIL commit_width: got %b want 0", commit);
    end
  endtask

  task automatic test_timeout();
    int seen;
    do_reset();
    set_time(5, 7);
    press(2'd2);
    press_n(2'd1, 18);
    total++;
    if (hr_bcd !== 8'h23) begin
      bad++;
      $display("FAIL hr_to_23: got %h want 23", hr_bcd);
    end
    press(2'd1);
    total++;
    if ({hr_bcd, min_bcd} !== 16'h0007) begin
      bad++;
      $display("FAIL hr_wrap: got %h:%h want 00:07", hr_bcd, min_bcd);
    end
    press(2'd2);
    press(2'd1);
    seen = 0;
    for (int i = 0; i < 99; i++) begin
      cyc(1);
      if (commit) seen++;
    end
    total++;
    if ({field_sel, min_bcd} !== {2'd2, 8'h08}) begin
      bad++;
      $display("FAIL before_timeout: got fs=%0d min=%h want 2 08", field_sel, min_bcd);
    end
    cyc(1);
    if (commit) seen++;
    total++;
    if ({field_sel, hr_bcd, min_bcd, commit} !== {2'd0, 16'h0507, 1'b0}) begin
      bad++;
      $display("FAIL timeout_abort: got fs=%0d %h:%h c=%b want 0 05:07 0",
               field_sel, hr_bcd, min_bcd, commit);
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL timeout_no_commit: got %0d commit cycles want 0", seen);
    end
    press(2'd2);
    cyc(49);
    press(2'd3);
    cyc(49);
    total++;
    if ({field_sel, hr_bcd, min_bcd} !== {2'd1, 16'h0507}) begin
      bad++;
      $display("FAIL code3_ignored: got fs=%0d %h:%h want 1 05:07", field_sel, hr_bcd, min_bcd);
    end
    cyc(1);
    total++;
    if (field_sel !== 2'd0) begin
      bad++;
      $display("FAIL code3_no_restart: got fs=%0d want 0", field_sel);
    end
  endtask

  task automatic test_tick_in_edit();
    do_reset();
    set_time(12, 30);
    tick_min = 1'b1;
    btn_state = 2'd2;
    cyc(1);
    btn_state = 2'd0;
    total++;
    if ({field_sel, hr_bcd, min_bcd} !== {2'd1, 16'h1230}) begin
      bad++;
      $display("FAIL tick_and_next: got fs=%0d %h:%h want 1 12:30", field_sel, hr_bcd, min_bcd);
    end
    cyc(3);
    tick_min = 1'b0;
    press(2'd2);
    press(2'd2);
    total++;
    if ({commit, hr_bcd, min_bcd} !== {1'b1, 16'h1230}) begin
      bad++;
      $display("FAIL ticks_dropped: got c=%b %h:%h want 1 12:30", commit, hr_bcd, min_bcd);
    end
    tick_min = 1'b1;
    cyc(1);
    tick_min = 1'b0;
    press(2'd1);
    total++;
    if ({field_sel, hr_bcd, min_bcd} !== {2'd0, 16'h1231}) begin
      bad++;
      $display("FAIL idle_step_ignored: got fs=%0d %h:%h want 0 12:31", field_sel, hr_bcd, min_bcd);
    end
  endtask

  task automatic test_blink();
`ifdef TIME_SET_BLINK_EN
    logic [6:0] got;
    do_reset();
    press(2'd2);
    got[0] = blink;
    cyc(9);
    got[1] = blink;
    cyc(1);
    got[2] = blink;
    cyc(5);
    press(2'd1);
    got[3] = blink;
    cyc(9);
    got[4] = blink;
    cyc(1);
    got[5] = blink;
    cyc(10);
    press(2'd2);
    cyc(9);
    got[6] = blink;
    total++;
    if (got !== 7'b1011011) begin
      bad++;
      $display("FAIL blink_phase: got %b want 1011011", got);
    end
    cyc(1);
    press(2'd2);
    total++;
    if (blink !== 1'b0) begin
      bad++;
      $display("FAIL blink_idle: got %b want 0", blink);
    end
`else
    int seen;
    do_reset();
    press(2'd2);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (blink) seen++;
    end
    press(2'd1);
    if (blink) seen++;
    press(2'd2);
    if (blink) seen++;
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL blink_tied: got %0d high cycles want 0", seen);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_tick_wrap();
    test_edit_commit();
    test_timeout();
    test_tick_in_edit();
    test_blink();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
